// File: rtl/rpc_cfg_boot_loader.sv
// rpc_cfg_boot_loader
//
// Boot-time configuration sequencer placed in front of the RPC DRAM controller's
// register-bus port. After reset it waits StartDelay cycles for DRAM power-up. It then
// writes cfg_num_i table entries (clamped to NumEntries) to the controller, retrying
// each entry up to MaxRetries times on an error response. Once the sequence ends, the
// external register-bus master is connected straight through to the controller.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_addr_i/cfg_data_i packed config table, entry k at [k*W +: W]
//   cfg_num_i             number of valid entries (clamped to NumEntries)
//   start_i               re-run request, accepted only when done and the bus is idle
//   ext_*                 external master request in / response out
//   reg_*                 controller request out / response in
//   busy_o, done_o        sequence running / pass-through active
//   err_o, err_idx_o      sticky abort flag and index of the entry that failed
module rpc_cfg_boot_loader #(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned NumEntries = 8,
   parameter int unsigned StartDelay = 200,
   parameter int unsigned MaxRetries = 2,
   localparam int unsigned StrbWidth = DataWidth / 8,
   localparam int unsigned NumWidth  = $clog2(NumEntries + 1),
   localparam int unsigned IdxWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumEntries*AddrWidth-1:0] cfg_addr_i,
   input  logic [NumEntries*DataWidth-1:0] cfg_data_i,
   input  logic [NumWidth-1:0]             cfg_num_i,
   input  logic                            start_i,
   input  logic [AddrWidth-1:0]            ext_addr_i,
   input  logic                            ext_write_i,
   input  logic [DataWidth-1:0]            ext_wdata_i,
   input  logic [StrbWidth-1:0]            ext_wstrb_i,
   input  logic                            ext_valid_i,
   output logic [DataWidth-1:0]            ext_rdata_o,
   output logic                            ext_error_o,
   output logic                            ext_ready_o,
   output logic [AddrWidth-1:0]            reg_addr_o,
   output logic                            reg_write_o,
   output logic [DataWidth-1:0]            reg_wdata_o,
   output logic [StrbWidth-1:0]            reg_wstrb_o,
   output logic                            reg_valid_o,
   input  logic [DataWidth-1:0]            reg_rdata_i,
   input  logic                            reg_error_i,
   input  logic                            reg_ready_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o,
   output logic [IdxWidth-1:0]             err_idx_o
);

   localparam int unsigned CntWidth   = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
   localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

   typedef enum logic [1:0] {
      StDelay,
      StWrite,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [IdxWidth-1:0]   idx_q, idx_d;
   logic [RetryWidth-1:0] retry_q, retry_d;
   logic                  err_q, err_d;
   logic [IdxWidth-1:0]   err_idx_q, err_idx_d;

   // Unpacked view of the packed config table.
   logic [AddrWidth-1:0] tbl_addr [NumEntries];
   logic [DataWidth-1:0] tbl_data [NumEntries];

   for (genvar k = 0; k < NumEntries; k++) begin : g_tbl
      assign tbl_addr[k] = cfg_addr_i[k*AddrWidth +: AddrWidth];
      assign tbl_data[k] = cfg_data_i[k*DataWidth +: DataWidth];
   end

   logic [NumWidth-1:0] num_eff;
   logic                num_zero;
   logic                is_last;
   logic                delay_over;
   logic                retry_left;

   assign num_eff    = (cfg_num_i > NumWidth'(NumEntries)) ? NumWidth'(NumEntries) : cfg_num_i;
   assign num_zero   = (num_eff == '0);
   // idx + 1 == num avoids the underflow of num - 1 when num is zero.
   assign is_last    = ((NumWidth'(idx_q) + NumWidth'(1)) == num_eff);
   assign delay_over = (cnt_q == CntWidth'(StartDelay));
   assign retry_left = (retry_q < RetryWidth'(MaxRetries));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;

      reg_addr_o  = '0;
      reg_write_o = 1'b0;
      reg_wdata_o = '0;
      reg_wstrb_o = '0;
      reg_valid_o = 1'b0;
      ext_rdata_o = '0;
      ext_error_o = 1'b0;
      ext_ready_o = 1'b0;

      unique case (state_q)
         StDelay: begin
            if (delay_over) begin
               state_d = num_zero ? StDone : StWrite;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end

         StWrite: begin
            reg_valid_o = 1'b1;
            reg_write_o = 1'b1;
            reg_wstrb_o = '1;
            reg_addr_o  = tbl_addr[idx_q];
            reg_wdata_o = tbl_data[idx_q];
            if (reg_ready_i) begin
               if (!reg_error_i) begin
                  retry_d = '0;
                  if (is_last) begin
                     state_d = StDone;
                  end else begin
                     // Next entry is presented straight away; valid never drops.
                     idx_d = idx_q + IdxWidth'(1);
                  end
               end else if (retry_left) begin
                  retry_d = retry_q + RetryWidth'(1);
               end else begin
                  err_d     = 1'b1;
                  err_idx_d = idx_q;
                  state_d   = StDone;
               end
            end
         end

         StDone: begin
            reg_addr_o  = ext_addr_i;
            reg_write_o = ext_write_i;
            reg_wdata_o = ext_wdata_i;
            reg_wstrb_o = ext_wstrb_i;
            reg_valid_o = ext_valid_i;
            ext_rdata_o = reg_rdata_i;
            ext_error_o = reg_error_i;
            ext_ready_o = reg_ready_i;
            // Only restart on an idle bus so an external transfer is never cut short.
            if (start_i && !ext_valid_i) begin
               idx_d   = '0;
               retry_d = '0;
               err_d   = 1'b0;
               if (!num_zero) begin
                  state_d = StWrite;
               end
            end
         end

         default: begin
            state_d = StDelay;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StDelay;
         cnt_q     <= '0;
         idx_q     <= '0;
         retry_q   <= '0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
      end
   end

   assign busy_o    = (state_q != StDone);
   assign done_o    = (state_q == StDone);
   assign err_o     = err_q;
   assign err_idx_o = err_idx_q;

endmodule

// File: doc/rpc_cfg_boot_loader.md
Name: rpc_cfg_boot_loader

Overview:
- Sits directly upstream of the RPC DRAM controller's register-bus configuration port (reg_req/reg_rsp).
- After reset, waits a programmable DRAM power-up delay, then writes a table of controller configuration registers over the register bus.
- When the sequence finishes, it becomes a transparent pass-through for the SoC's external register-bus master.
- Also exposes done, error and index status for SoC boot firmware.

Parameters:
- AddrWidth, 32, register-bus address width
- DataWidth, 32, register-bus data width (wstrb width = DataWidth/8)
- NumEntries, 8, config-table depth (>=1)
- StartDelay, 200, clock cycles waited after reset before the first write (>=0)
- MaxRetries, 2, retries per entry on error response (>=0)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_addr_i  in  NumEntries*AddrWidth  table addresses; entry k at [k*AddrWidth +: AddrWidth]
- cfg_data_i  in  NumEntries*DataWidth  table write data, same packing
- cfg_num_i  in  $clog2(NumEntries+1)  valid entries; entries 0..cfg_num_i-1 are written
- start_i  in  1  re-run pulse; skips the delay
- ext_addr_i  in  AddrWidth  external master address
- ext_write_i  in  1  external master write
- ext_wdata_i  in  DataWidth  external master write data
- ext_wstrb_i  in  DataWidth/8  external master write strobe
- ext_valid_i  in  1  external master request valid
- ext_rdata_o  out  DataWidth  response read data to the external master
- ext_error_o  out  1  response error to the external master
- ext_ready_o  out  1  response ready to the external master
- reg_addr_o  out  AddrWidth  request address to the controller
- reg_write_o  out  1  request write to the controller
- reg_wdata_o  out  DataWidth  request write data to the controller
- reg_wstrb_o  out  DataWidth/8  request write strobe to the controller
- reg_valid_o  out  1  request valid to the controller
- reg_rdata_i  in  DataWidth  controller response read data
- reg_error_i  in  1  controller response error
- reg_ready_i  in  1  controller response ready
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence finished; pass-through active
- err_o  out  1  sticky error
- err_idx_o  out  $clog2(NumEntries)  index of the failing entry

Behaviour:
- Reset (async, active-high): state=DELAY, delay counter=0, idx=0, retry=0.
  - All reg_* outputs 0; ext_* outputs 0.
  - busy_o=1, done_o=0, err_o=0, err_idx_o=0.
- Register-bus handshake:
  - A transfer completes in a cycle where valid=1 and ready=1. ready may be combinational from valid.
  - Once reg_valid_o is raised, it and addr/wdata are held stable until ready.
- FSM states: DELAY, WRITE, DONE.
- DELAY:
  - Counter increments each cycle.
  - When counter == StartDelay, go to WRITE, or to DONE if cfg_num_i==0.
  - StartDelay=0 leaves DELAY after exactly one cycle.
- WRITE:
  - reg_valid_o=1, reg_write_o=1, reg_wstrb_o=all ones, reg_addr_o/reg_wdata_o = entry idx.
  - On ready with error=0: retry:=0.
    - If idx==cfg_num_i-1, go to DONE.
    - Else idx++; the next entry is driven the following cycle, so reg_valid_o stays high with no idle cycle.
  - On ready with error=1 and retry<MaxRetries: retry++ and the same entry is reissued the next cycle.
  - On ready with error=1 and retry==MaxRetries: err_o:=1, err_idx_o:=idx, go to DONE (abort).
- cfg_* inputs are sampled live and must be static while busy_o=1.
- DONE:
  - busy_o=0, done_o=1.
  - reg_* = ext_* and ext_* = reg_* combinationally, with zero added latency.
- Outside DONE:
  - ext_ready_o=0, ext_error_o=0, ext_rdata_o=0.
  - ext_valid_i is ignored (no request is forwarded).
- start_i:
  - Accepted only in DONE with ext_valid_i=0. This never truncates an external transfer.
  - On acceptance: idx:=0, retry:=0, err_o:=0, go to WRITE (or stay DONE if cfg_num_i==0). done_o drops the next cycle.
  - Ignored in DELAY and WRITE, or when ext_valid_i=1.
- cfg_num_i > NumEntries: clamp to NumEntries.
- Reset asserted mid-write: everything returns to reset values immediately. The sequence restarts from DELAY after reset is released.

Test Plan:
- StartDelay=4, cfg_num_i=3, reg_ready_i tied 1, no errors:
  - reg_valid_o first rises 5 cycles after reset release.
  - 3 consecutive writes to entries 0,1,2 with no gaps.
  - done_o=1 the cycle after the third handshake; err_o=0.
- Controller ready delayed 3 cycles per request:
  - addr/wdata held stable across the wait cycles.
  - idx advances only on ready.
- Entry 1 returns error twice, then OK, with MaxRetries=2:
  - entry 1 issued 3 times; sequence completes; err_o=0.
- Entry 2 errors 3 times, with MaxRetries=2:
  - abort; err_o=1, err_idx_o=2, done_o=1.
  - Entries 3+ are never issued.
- In DONE, external read at 0x10 with controller rdata=0xDEADBEEF:
  - ext_rdata_o=0xDEADBEEF and ext_ready_o=1 in the same cycle.
  - Before done_o, ext_ready_o stays 0 for the whole sequence.
- start_i pulsed while ext_valid_i=1:
  - ignored.
  - Pulsed again with ext_valid_i=0: rewrite of entries 0..cfg_num_i-1 with no delay phase, and err_o cleared.
- Reset asserted during the second write:
  - all outputs return to reset values.
  - After release, the full sequence reruns starting with the delay.
